// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
//   Serial bit-stream generator. It captures a parallel pattern, a bit count
//   and a repeat count, then shifts pattern[len-1:0] out MSB-first, one bit
//   per clock. It can insert an optional idle gap between repetitions.
//
// Parameters
//   WIDTH    - maximum pattern length in bits
//   LEN_W    - width of the length field (2**LEN_W > WIDTH)
//   REP_W    - width of the repeat-count field
//   GAP_CYC  - idle cycles inserted between repetitions (0 = back-to-back)
//   IDLE_BIT - level on dout_o whenever no pattern bit is being sent
//
// Ports
//   clk_i        - system clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   start_i      - send request, sampled only in IDLE
//   pattern_i    - bits to send; the active field is pattern_i[len_i-1:0]
//   len_i        - bits per repetition, legal range 1..WIDTH
//   repeat_n_i   - extra repetitions after the first
//   abort_i      - synchronous cancel of a transfer in flight
//   dout_o       - registered serial data
//   bit_valid_o  - high while dout_o carries a pattern bit
//   busy_o       - high through the bits and gaps of a transfer
//   done_o       - one-cycle pulse after the final bit of the final repetition
// ---------------------------------------------------------------------------
module serial_pattern_tx #(
   parameter int WIDTH    = 8,
   parameter int LEN_W    = 4,
   parameter int REP_W    = 4,
   parameter int GAP_CYC  = 0,
   parameter bit IDLE_BIT = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] pattern_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [REP_W-1:0] repeat_n_i,
   input  logic             abort_i,
   output logic             dout_o,
   output logic             bit_valid_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(WIDTH);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] pat_q;     // captured pattern
   logic [LEN_W-1:0] len_q;     // captured length
   logic [LEN_W-1:0] idx_q;     // index of the bit currently on dout_o
   logic [REP_W-1:0] rep_q;     // repetitions still to send after this one
   logic [GAP_W-1:0] gap_q;     // gap cycles remaining after this one
   logic             dout_q;
   logic             bit_valid_q;
   logic             busy_q;
   logic             done_q;

   logic             len_ok_d;
   logic             start_bit_d;
   logic             first_bit_d;
   logic             next_bit_d;

   // Bit select by a run-time index written as a masked reduction so every
   // bit of the source vector is used and no index-width mismatch arises.
   function automatic logic bit_at(input logic [WIDTH-1:0] v,
                                   input logic [LEN_W-1:0] i);
      return |(v & (ONE_HOT0 << i));
   endfunction

   assign len_ok_d    = (len_i != '0) && (len_i <= MAX_LEN);
   assign start_bit_d = bit_at(pattern_i, len_i - 1'b1);
   assign first_bit_d = bit_at(pat_q, len_q - 1'b1);
   assign next_bit_d  = bit_at(pat_q, idx_q - 1'b1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         pat_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         rep_q       <= '0;
         gap_q       <= '0;
         dout_q      <= IDLE_BIT;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               // abort beats a simultaneous start; bad lengths are dropped
               if (start_i && !abort_i && len_ok_d) begin
                  state_q     <= S_SHIFT;
                  pat_q       <= pattern_i;
                  len_q       <= len_i;
                  rep_q       <= repeat_n_i;
                  idx_q       <= len_i - 1'b1;
                  dout_q      <= start_bit_d;
                  bit_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end

            S_SHIFT: begin
               if (abort_i) begin
                  state_q     <= S_IDLE;
                  dout_q      <= IDLE_BIT;
                  bit_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end else if (idx_q != '0) begin
                  idx_q  <= idx_q - 1'b1;
                  dout_q <= next_bit_d;
               end else if (rep_q != '0) begin
                  rep_q <= rep_q - 1'b1;
                  idx_q <= len_q - 1'b1;
                  if (GAP_CYC > 0) begin
                     state_q     <= S_GAP;
                     gap_q       <= GAP_LAST;
                     dout_q      <= IDLE_BIT;
                     bit_valid_q <= 1'b0;
                  end else begin
                     dout_q <= first_bit_d;
                  end
               end else begin
                  state_q     <= S_DONE;
                  dout_q      <= IDLE_BIT;
                  bit_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end
            end

            S_GAP: begin
               if (abort_i) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (gap_q == '0) begin
                  // idx_q was already reloaded when the gap was entered
                  state_q     <= S_SHIFT;
                  dout_q      <= first_bit_d;
                  bit_valid_q <= 1'b1;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end

            default: begin
               state_q     <= S_IDLE;
               dout_q      <= IDLE_BIT;
               bit_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
            end
         endcase
      end
   end

   assign dout_o      = dout_q;
   assign bit_valid_o = bit_valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
